// File: rtl/march_result_checker.sv
// ---------------------------------------------------------------------------
// march_result_checker
//
// BIST response checker for the March engine. Each SRAM read word is compared
// against the expected March background under a per-bit mask. A two-stage
// pipeline does the work: stage 1 registers the masked difference, and
// stage 2 retires it into the result registers. The result registers are a
// sticky fail flag, a saturating miscompare count, an accumulated per-bit
// fail map, and a capture of the first failing address and data.
// With STOP_ON_FAIL=1 the checker halts the controller on the first failure.
//
// Parameters:
//   DW           data word width
//   AW           address width
//   CW           fail counter width
//   STOP_ON_FAIL 1 = enter HALT on the first miscompare
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, done      arm checker / March sequence finished
//   clear            synchronous clear of all results, back to IDLE
//   cmp_valid        compare strobe for cmp_addr/exp_data/rd_data/bit_mask
//   busy, halt       state is RUN / state is HALT
//   fail             sticky miscompare flag
//   fail_pulse       one-cycle pulse per miscompare
//   fail_count       saturating miscompare count
//   fail_bits        OR of all masked difference vectors
//   first_valid      first-fail capture holds data
//   first_addr/exp/act  first failing address, expected and read data
// ---------------------------------------------------------------------------
module march_result_checker #(
  parameter int DW           = 4,
  parameter int AW           = 8,
  parameter int CW           = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          done,
  input  logic          clear,
  input  logic          cmp_valid,
  input  logic [AW-1:0] cmp_addr,
  input  logic [DW-1:0] exp_data,
  input  logic [DW-1:0] rd_data,
  input  logic [DW-1:0] bit_mask,
  output logic          busy,
  output logic          halt,
  output logic          fail,
  output logic          fail_pulse,
  output logic [CW-1:0] fail_count,
  output logic [DW-1:0] fail_bits,
  output logic          first_valid,
  output logic [AW-1:0] first_addr,
  output logic [DW-1:0] first_exp,
  output logic [DW-1:0] first_act
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e        state_q, state_d;

  // Stage 1: masked difference plus the operands needed for first-fail capture
  logic          v1_q, v1_d;
  logic [DW-1:0] diff1_q, diff1_d;
  logic [AW-1:0] addr1_q, addr1_d;
  logic [DW-1:0] exp1_q, exp1_d;
  logic [DW-1:0] act1_q, act1_d;

  // Result registers
  logic          fail_q, fail_d;
  logic          fail_pulse_q, fail_pulse_d;
  logic [CW-1:0] fail_count_q, fail_count_d;
  logic [DW-1:0] fail_bits_q, fail_bits_d;
  logic          first_valid_q, first_valid_d;
  logic [AW-1:0] first_addr_q, first_addr_d;
  logic [DW-1:0] first_exp_q, first_exp_d;
  logic [DW-1:0] first_act_q, first_act_d;

  logic          miscompare;

  // Stage 2 keeps retiring in IDLE so a compare in flight at done still counts
  assign miscompare = v1_q && (state_q != HALT) && (diff1_q != '0);

  always_comb begin
    state_d       = state_q;
    v1_d          = 1'b0;
    diff1_d       = diff1_q;
    addr1_d       = addr1_q;
    exp1_d        = exp1_q;
    act1_d        = act1_q;
    fail_d        = fail_q;
    fail_pulse_d  = 1'b0;
    fail_count_d  = fail_count_q;
    fail_bits_d   = fail_bits_q;
    first_valid_d = first_valid_q;
    first_addr_d  = first_addr_q;
    first_exp_d   = first_exp_q;
    first_act_d   = first_act_q;

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (STOP_ON_FAIL && miscompare) state_d = HALT;
        else if (done)                  state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (miscompare) begin
      fail_d       = 1'b1;
      fail_pulse_d = 1'b1;
      if (fail_count_q != {CW{1'b1}}) fail_count_d = fail_count_q + CW'(1);
      fail_bits_d  = fail_bits_q | diff1_q;
      if (!first_valid_q) begin
        first_valid_d = 1'b1;
        first_addr_d  = addr1_q;
        first_exp_d   = exp1_q;
        first_act_d   = act1_q;
      end
    end

    // Entering HALT flushes stage 1, so the compare arriving now is discarded
    if ((state_q == RUN) && cmp_valid && (state_d != HALT)) begin
      v1_d    = 1'b1;
      diff1_d = (exp_data ^ rd_data) & bit_mask;
      addr1_d = cmp_addr;
      exp1_d  = exp_data;
      act1_d  = rd_data;
    end

    // clear overrides everything, including a same-cycle compare
    if (clear) begin
      state_d       = IDLE;
      v1_d          = 1'b0;
      diff1_d       = '0;
      addr1_d       = '0;
      exp1_d        = '0;
      act1_d        = '0;
      fail_d        = 1'b0;
      fail_pulse_d  = 1'b0;
      fail_count_d  = '0;
      fail_bits_d   = '0;
      first_valid_d = 1'b0;
      first_addr_d  = '0;
      first_exp_d   = '0;
      first_act_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      v1_q          <= 1'b0;
      diff1_q       <= '0;
      addr1_q       <= '0;
      exp1_q        <= '0;
      act1_q        <= '0;
      fail_q        <= 1'b0;
      fail_pulse_q  <= 1'b0;
      fail_count_q  <= '0;
      fail_bits_q   <= '0;
      first_valid_q <= 1'b0;
      first_addr_q  <= '0;
      first_exp_q   <= '0;
      first_act_q   <= '0;
    end else begin
      state_q       <= state_d;
      v1_q          <= v1_d;
      diff1_q       <= diff1_d;
      addr1_q       <= addr1_d;
      exp1_q        <= exp1_d;
      act1_q        <= act1_d;
      fail_q        <= fail_d;
      fail_pulse_q  <= fail_pulse_d;
      fail_count_q  <= fail_count_d;
      fail_bits_q   <= fail_bits_d;
      first_valid_q <= first_valid_d;
      first_addr_q  <= first_addr_d;
      first_exp_q   <= first_exp_d;
      first_act_q   <= first_act_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign halt        = (state_q == HALT);
  assign fail        = fail_q;
  assign fail_pulse  = fail_pulse_q;
  assign fail_count  = fail_count_q;
  assign fail_bits   = fail_bits_q;
  assign first_valid = first_valid_q;
  assign first_addr  = first_addr_q;
  assign first_exp   = first_exp_q;
  assign first_act   = first_act_q;

endmodule

// File: tb/tb_march_result_checker.sv
// ---------------------------------------------------------------------------
// tb_march_result_checker
//
// Directed bench for march_result_checker. Three instances share one set of
// stimulus inputs:
//   dut      - defaults (CW=8, STOP_ON_FAIL=0)
//   dut_sat  - CW=2, for counter saturation
//   dut_stop - STOP_ON_FAIL=1, for halt behaviour
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at that same point.
// ---------------------------------------------------------------------------
module tb_march_result_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, done, clear, cmp_valid;
  logic [7:0] cmp_addr;
  logic [3:0] exp_data, rd_data, bit_mask;

  logic       busy, halt, fail, fail_pulse, first_valid;
  logic [7:0] fail_count, first_addr;
  logic [3:0] fail_bits, first_exp, first_act;

  logic       s_busy, s_halt, s_fail, s_pulse, s_fv;
  logic [1:0] s_count;
  logic [7:0] s_faddr;
  logic [3:0] s_bits, s_fexp, s_fact;

  logic       p_busy, p_halt, p_fail, p_pulse, p_fv;
  logic [7:0] p_count, p_faddr;
  logic [3:0] p_bits, p_fexp, p_fact;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  march_result_checker #(.DW(4), .AW(8), .CW(8), .STOP_ON_FAIL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .clear(clear),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .exp_data(exp_data),
    .rd_data(rd_data), .bit_mask(bit_mask), .busy(busy), .halt(halt),
    .fail(fail), .fail_pulse(fail_pulse), .fail_count(fail_count),
    .fail_bits(fail_bits), .first_valid(first_valid), .first_addr(first_addr),
    .first_exp(first_exp), .first_act(first_act)
  );

  march_result_checker #(.DW(4), .AW(8), .CW(2), .STOP_ON_FAIL(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .clear(clear),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .exp_data(exp_data),
    .rd_data(rd_data), .bit_mask(bit_mask), .busy(s_busy), .halt(s_halt),
    .fail(s_fail), .fail_pulse(s_pulse), .fail_count(s_count),
    .fail_bits(s_bits), .first_valid(s_fv), .first_addr(s_faddr),
    .first_exp(s_fexp), .first_act(s_fact)
  );

  march_result_checker #(.DW(4), .AW(8), .CW(8), .STOP_ON_FAIL(1'b1)) dut_stop (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .clear(clear),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .exp_data(exp_data),
    .rd_data(rd_data), .bit_mask(bit_mask), .busy(p_busy), .halt(p_halt),
    .fail(p_fail), .fail_pulse(p_pulse), .fail_count(p_count),
    .fail_bits(p_bits), .first_valid(p_fv), .first_addr(p_faddr),
    .first_exp(p_fexp), .first_act(p_fact)
  );

  // Advance one clock and settle just past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one compare for the next edge
  task automatic apply_cmp(input logic [7:0] a, input logic [3:0] e,
                           input logic [3:0] r, input logic [3:0] m);
    cmp_valid = 1'b1;
    cmp_addr  = a;
    exp_data  = e;
    rd_data   = r;
    bit_mask  = m;
  endtask

  // Clear all three instances, then arm them
  task automatic clear_and_start();
    cmp_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; done = 0; clear = 0; cmp_valid = 0;
    cmp_addr = 0; exp_data = 0; rd_data = 0; bit_mask = 0;
    tick();
    tick();
    checks++;
    if ({busy, halt, fail, fail_pulse, fail_count, fail_bits, first_valid,
         first_addr, first_exp, first_act} !== 36'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%0h exp=0", {busy, halt, fail, fail_pulse,
               fail_count, fail_bits, first_valid, first_addr, first_exp, first_act});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_pass();
    clear_and_start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL clean_busy_on got=%b exp=1", busy); end
    for (int i = 0; i < 256; i++) begin
      apply_cmp(8'(i), 4'hA, 4'hA, 4'hF);
      tick();
    end
    cmp_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL clean_busy_before_done got=%b exp=1", busy); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL clean_busy_after_done got=%b exp=0", busy); end
    tick();
    tick();
    checks++;
    if ({fail, fail_count, fail_bits} !== 13'h0) begin
      failures++;
      $display("[TB] FAIL clean_results got fail=%b count=%0d bits=%h exp 0/0/0", fail, fail_count, fail_bits);
    end
  endtask

  task automatic test_single_fault();
    clear_and_start();
    apply_cmp(8'h37, 4'h5, 4'h4, 4'hF);
    tick();
    cmp_valid = 1'b0;
    checks++;
    if (fail_pulse !== 1'b0) begin failures++; $display("[TB] FAIL single_pulse_early got=%b exp=0", fail_pulse); end
    tick();
    checks++;
    if (fail_pulse !== 1'b1) begin failures++; $display("[TB] FAIL single_pulse got=%b exp=1", fail_pulse); end
    checks++;
    if (fail_count !== 8'd1 || fail_bits !== 4'h1 || fail !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_count_bits got count=%0d bits=%h fail=%b exp 1/1/1", fail_count, fail_bits, fail);
    end
    checks++;
    if (first_valid !== 1'b1 || first_addr !== 8'h37 || first_exp !== 4'h5 || first_act !== 4'h4) begin
      failures++;
      $display("[TB] FAIL single_first got v=%b a=%h e=%h r=%h exp 1/37/5/4",
               first_valid, first_addr, first_exp, first_act);
    end
    tick();
    checks++;
    if (fail_pulse !== 1'b0) begin failures++; $display("[TB] FAIL single_pulse_width got=%b exp=0", fail_pulse); end
  endtask

  task automatic test_mask_accum();
    clear_and_start();
    apply_cmp(8'h01, 4'hF, 4'h0, 4'h0);
    tick();
    apply_cmp(8'h10, 4'h2, 4'h0, 4'hF);
    tick();
    checks++;
    if (fail_pulse !== 1'b0 || fail !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mask_pass got pulse=%b fail=%b exp 0/0", fail_pulse, fail);
    end
    apply_cmp(8'h20, 4'h8, 4'h0, 4'hF);
    tick();
    cmp_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (fail_bits !== 4'hA || fail_count !== 8'd2) begin
      failures++;
      $display("[TB] FAIL accum got bits=%h count=%0d exp A/2", fail_bits, fail_count);
    end
    checks++;
    if (first_addr !== 8'h10 || first_exp !== 4'h2 || first_act !== 4'h0) begin
      failures++;
      $display("[TB] FAIL accum_first got a=%h e=%h r=%h exp 10/2/0", first_addr, first_exp, first_act);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_seq [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    clear_and_start();
    for (int i = 0; i < 6; i++) begin
      apply_cmp(8'(i), 4'h1, 4'h0, 4'hF);
      tick();
      if (i > 0) begin
        checks++;
        if (s_count !== exp_seq[i-1] || s_pulse !== 1'b1) begin
          failures++;
          $display("[TB] FAIL sat_step%0d got count=%0d pulse=%b exp %0d/1", i, s_count, s_pulse, exp_seq[i-1]);
        end
      end
    end
    cmp_valid = 1'b0;
    tick();
    checks++;
    if (s_count !== exp_seq[5] || s_pulse !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_step6 got count=%0d pulse=%b exp 3/1", s_count, s_pulse);
    end
    tick();
    checks++;
    if (s_pulse !== 1'b0 || s_count !== 2'd3) begin
      failures++;
      $display("[TB] FAIL sat_end got count=%0d pulse=%b exp 3/0", s_count, s_pulse);
    end
  endtask

  task automatic test_stop_on_fail();
    clear_and_start();
    apply_cmp(8'h05, 4'h3, 4'h1, 4'hF);
    tick();
    apply_cmp(8'h06, 4'h3, 4'h0, 4'hF);
    tick();
    cmp_valid = 1'b0;
    checks++;
    if (p_halt !== 1'b1 || p_busy !== 1'b0 || p_pulse !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stop_halt got halt=%b busy=%b pulse=%b exp 1/0/1", p_halt, p_busy, p_pulse);
    end
    tick();
    tick();
    checks++;
    if (p_count !== 8'd1 || p_faddr !== 8'h05 || p_bits !== 4'h2 || p_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stop_flush got count=%0d addr=%h bits=%h pulse=%b exp 1/05/2/0",
               p_count, p_faddr, p_bits, p_pulse);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (p_halt !== 1'b1 || p_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stop_ignore_start got halt=%b busy=%b exp 1/0", p_halt, p_busy);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({p_busy, p_halt, p_fail, p_pulse, p_count, p_bits, p_fv, p_faddr, p_fexp, p_fact} !== 36'h0) begin
      failures++;
      $display("[TB] FAIL stop_clear got=%0h exp=0",
               {p_busy, p_halt, p_fail, p_pulse, p_count, p_bits, p_fv, p_faddr, p_fexp, p_fact});
    end
  endtask

  task automatic test_clear_collision();
    clear_and_start();
    apply_cmp(8'h44, 4'hF, 4'h0, 4'hF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cmp_valid = 1'b0;
    tick();
    checks++;
    if (fail_pulse !== 1'b0 || fail_count !== 8'd0 || fail !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_collision got pulse=%b count=%0d fail=%b busy=%b exp 0/0/0/0",
               fail_pulse, fail_count, fail, busy);
    end
  endtask

  task automatic test_reset_midrun();
    clear_and_start();
    apply_cmp(8'h11, 4'h1, 4'h0, 4'hF);
    tick();
    apply_cmp(8'h12, 4'h4, 4'h0, 4'hF);
    tick();
    cmp_valid = 1'b0;
    checks++;
    if (fail_count !== 8'd1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrun_pre got count=%0d busy=%b exp 1/1", fail_count, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, halt, fail, fail_pulse, fail_count, fail_bits, first_valid,
         first_addr, first_exp, first_act} !== 36'h0) begin
      failures++;
      $display("[TB] FAIL midrun_async got=%0h exp=0", {busy, halt, fail, fail_pulse,
               fail_count, fail_bits, first_valid, first_addr, first_exp, first_act});
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (fail_pulse !== 1'b0 || fail_count !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrun_lost got pulse=%b count=%0d busy=%b exp 0/0/0", fail_pulse, fail_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_single_fault();
    test_mask_accum();
    test_saturation();
    test_stop_on_fail();
    test_clear_collision();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
